// File: rtl/fpadd_pkg.sv
// Shared types and constants for the serial FP adder feeder.
package fpadd_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_DRV_A = 2'd1,
    ST_DRV_B = 2'd2,
    ST_WAIT  = 2'd3
  } feed_state_e;

  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
  } op_pair_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with same-cycle push/pop and a look-ahead occupancy output.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             full_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty      = (level_r == LW'(0));
  assign full_s     = (level_r == LVL_FULL);
  assign pop_ok_s   = pop & ~empty;
  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign push_ok_s  = push & (~full_s | pop_ok_s);
  assign level_next = level_r + LW'(push_ok_s) - LW'(pop_ok_s);
  assign rdata      = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= AW'(0);
      rd_ptr_r <= AW'(0);
      level_r  <= LW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      level_r <= level_next;
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
    end
  end

endmodule

// File: rtl/fpadd_feeder.sv
// Operand feeder and result collector for the free-running serial FP adder:
// aligns operand pairs to the adder's sample slots and returns sums in order.
module fpadd_feeder
  import fpadd_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_sum,
  input  logic            add_ready,
  output logic [31:0]     add_a,
  input  logic [31:0]     add_sum,
  output logic            err
);

  localparam int IN_LW  = $clog2(DEPTH) + 1;
  localparam int OUT_LW = 2;
  localparam int WD_W   = $clog2(TIMEOUT) + 1;
  localparam logic [IN_LW-1:0] IN_FULL  = IN_LW'(DEPTH);
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT - 1);

  feed_state_e      state_r;
  feed_state_e      state_next_s;
  logic             ready_q_r;
  logic             outstanding_r;
  logic             real_r;
  logic             err_r;
  logic             in_ready_r;
  logic [FP_W-1:0]  add_a_r;
  logic [FP_W-1:0]  add_a_next_s;
  logic [FP_W-1:0]  hold_b_r;
  logic [WD_W-1:0]  wd_cnt_r;

  op_pair_t          in_wdata_s;
  op_pair_t          in_head_s;
  logic              in_empty_s;
  logic [IN_LW-1:0]  in_level_next_s;
  logic              out_empty_s;
  logic [OUT_LW-1:0] out_level_next_s;

  logic rise_s, decide_s, capture_s, issue_s, timeout_s, in_push_s, out_pop_s;

  assign in_wdata_s = '{a: in_a, b: in_b};
  assign in_push_s  = in_valid & in_ready_r;
  assign out_pop_s  = ~out_empty_s & out_ready;
  assign rise_s     = add_ready & ~ready_q_r;
  assign decide_s   = rise_s & ((state_r == ST_SYNC) | (state_r == ST_WAIT));
  assign capture_s  = decide_s & outstanding_r;
  // Only issue if the result will still have a buffer slot when it lands.
  assign issue_s    = decide_s & ~in_empty_s & (out_level_next_s <= 2'd1);
  assign timeout_s  = outstanding_r & ~decide_s & (wd_cnt_r == WD_LIMIT);

  sync_fifo #(.WIDTH($bits(op_pair_t)), .DEPTH(DEPTH)) u_in_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (in_push_s),
    .wdata      (in_wdata_s),
    .pop        (issue_s),
    .rdata      (in_head_s),
    .empty      (in_empty_s),
    .level_next (in_level_next_s)
  );

  sync_fifo #(.WIDTH(FP_W), .DEPTH(2)) u_out_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (capture_s),
    .wdata      (add_sum),
    .pop        (out_pop_s),
    .rdata      (out_sum),
    .empty      (out_empty_s),
    .level_next (out_level_next_s)
  );

  // Next state and the value to present on the adder A port next cycle.
  always_comb begin
    state_next_s = state_r;
    add_a_next_s = FP_ZERO;
    if (timeout_s) begin
      state_next_s = ST_SYNC;
      add_a_next_s = FP_ZERO;
    end else begin
      case (state_r)
        ST_SYNC, ST_WAIT: begin
          if (decide_s) begin
            state_next_s = ST_DRV_A;
            add_a_next_s = issue_s ? in_head_s.a : FP_ZERO;
          end else begin
            state_next_s = state_r;
          end
        end
        ST_DRV_A: begin
          state_next_s = ST_DRV_B;
          add_a_next_s = real_r ? hold_b_r : FP_ZERO;
        end
        ST_DRV_B: state_next_s = ST_WAIT;
        default:  state_next_s = ST_SYNC;
      endcase
    end
  end

  // State, adder drive, outstanding-job tracking and watchdog.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_SYNC;
      ready_q_r     <= 1'b0;
      outstanding_r <= 1'b0;
      real_r        <= 1'b0;
      err_r         <= 1'b0;
      in_ready_r    <= 1'b0;
      add_a_r       <= FP_ZERO;
      hold_b_r      <= FP_ZERO;
      wd_cnt_r      <= {WD_W{1'b0}};
    end else begin
      state_r    <= state_next_s;
      ready_q_r  <= add_ready;
      add_a_r    <= add_a_next_s;
      in_ready_r <= (in_level_next_s != IN_FULL);
      if (decide_s) begin
        real_r <= issue_s;
      end
      if (issue_s) begin
        hold_b_r      <= in_head_s.b;
        outstanding_r <= 1'b1;
        wd_cnt_r      <= {WD_W{1'b0}};
      end else if (capture_s | timeout_s) begin
        outstanding_r <= 1'b0;
        wd_cnt_r      <= {WD_W{1'b0}};
      end else if (outstanding_r) begin
        wd_cnt_r <= wd_cnt_r + WD_W'(1);
      end
      if (timeout_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign add_a     = add_a_r;
  assign in_ready  = in_ready_r;
  assign out_valid = ~out_empty_s;
  assign err       = err_r;

endmodule
